// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register with a valid/ready load handshake.
// Words can be streamed back to back: a new word loads on the same edge that consumes the last bit.
module piso_shift_register #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             Q,
    output logic             Q_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;

    logic             last_bit;
    logic [WIDTH-1:0] shreg_shifted;
    logic             out_bit;

    // The edge that consumes the last bit is also the edge that may accept the next word.
    assign last_bit   = (state_q == SHIFT) && shift_en && (cnt_q == CW'(1));
    assign load_ready = (state_q == IDLE) || last_bit;

    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};
    assign out_bit       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    assign Q_valid = (state_q == SHIFT);
    assign busy    = (state_q == SHIFT);
    assign Q       = Q_valid ? out_bit : 1'b0;
    assign done    = done_q;

    // NOTE: all state is updated with non-blocking assignments so every
    // right-hand side sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        shreg_q <= load_data;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (cnt_q == CW'(1)) begin
                            done_q <= 1'b1;
                            if (load_valid) begin
                                shreg_q <= load_data;
                                cnt_q   <= CW'(WIDTH);
                            end else begin
                                state_q <= IDLE;
                                shreg_q <= '0;
                                cnt_q   <= '0;
                            end
                        end else begin
                            shreg_q <= shreg_shifted;
                            cnt_q   <= cnt_q - CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    shreg_q <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // An empty counter and the idle state must always coincide.
    a_cnt_idle: assert property (@(posedge clk) disable iff (reset)
        (cnt_q == '0) == (state_q == IDLE));

endmodule
